burst_mode_controller: RTL and testbench

//  Sequences the NCO/waveform path into N-cycle bursts separated by idle gaps.

---
 rtl/burst_mode_controller_if.sv | 29 ++
 rtl/burst_mode_controller.sv | 129 ++++++++++++
 tb/tb_burst_mode_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/burst_mode_controller_if.sv
// Signal bundle between the burst controller, the NCO phase accumulator and the waveform mux.
// The slave modport is the controller side; the master modport is whoever drives the config.
interface burst_mode_controller_if #(
    parameter int unsigned CYC_W = 16,
    parameter int unsigned GAP_W = 24
);
    logic             enable;
    logic             trig_mode;
    logic             trig;
    logic [CYC_W-1:0] burst_cycles;
    logic [GAP_W-1:0] gap_ticks;
    logic             phase_msb;
    logic             nco_clear;
    logic             out_gate;
    logic             busy;
    logic             burst_done;
    logic [CYC_W-1:0] cycle_count;
    logic [1:0]       state;

    modport master (
        output enable, trig_mode, trig, burst_cycles, gap_ticks, phase_msb,
        input  nco_clear, out_gate, busy, burst_done, cycle_count, state
    );

    modport slave (
        input  enable, trig_mode, trig, burst_cycles, gap_ticks, phase_msb,
        output nco_clear, out_gate, busy, burst_done, cycle_count, state
    );
endinterface

// File: rtl/burst_mode_controller.sv
// Gates the NCO/waveform path into bursts of N phase-accumulator wraps separated by idle gaps.
// Pass-through when disabled; auto-repeat or single-shot on trig otherwise.
module burst_mode_controller #(
    parameter int unsigned CYC_W = 16,
    parameter int unsigned GAP_W = 24
) (
    input logic                   clk,
    input logic                   rst_n,
    burst_mode_controller_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StBurst = 2'd2,
        StGap   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             nco_clear_q, nco_clear_d;
    logic             out_gate_q, out_gate_d;
    logic             busy_q, busy_d;
    logic             burst_done_q, burst_done_d;
    logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
    logic [CYC_W-1:0] tgt_q, tgt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             msb_q;
    logic             wrap;

    assign wrap = msb_q & ~bus.phase_msb;

    always_comb begin
        state_d       = state_q;
        nco_clear_d   = nco_clear_q;
        out_gate_d    = out_gate_q;
        burst_done_d  = 1'b0;
        cycle_count_d = cycle_count_q;
        tgt_d         = tgt_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt_q;

        if (!bus.enable) begin
            state_d     = StIdle;
            nco_clear_d = 1'b0;
            out_gate_d  = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    nco_clear_d = 1'b1;
                    out_gate_d  = 1'b0;
                    if (!bus.trig_mode || bus.trig) state_d = StStart;
                end
                StStart: begin
                    // Config is frozen here so mid-burst edits only apply to the next burst
                    tgt_d = (bus.burst_cycles == '0) ? CYC_W'(1) : bus.burst_cycles;
                    gap_d = (bus.gap_ticks == '0) ? GAP_W'(1) : bus.gap_ticks;
                    cycle_count_d = '0;
                    nco_clear_d   = 1'b0;
                    out_gate_d    = 1'b1;
                    state_d       = StBurst;
                end
                StBurst: begin
                    nco_clear_d = 1'b0;
                    out_gate_d  = 1'b1;
                    if (wrap) begin
                        if (cycle_count_q == tgt_q - CYC_W'(1)) begin
                            cycle_count_d = tgt_q;
                            burst_done_d  = 1'b1;
                            nco_clear_d   = 1'b1;
                            out_gate_d    = 1'b0;
                            gap_cnt_d     = gap_q;
                            state_d       = StGap;
                        end else if (cycle_count_q != '1) begin
                            cycle_count_d = cycle_count_q + CYC_W'(1);
                        end
                    end
                end
                StGap: begin
                    nco_clear_d = 1'b1;
                    out_gate_d  = 1'b0;
                    if (gap_cnt_q <= GAP_W'(1)) begin
                        state_d = bus.trig_mode ? StIdle : StStart;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            nco_clear_q   <= 1'b0;
            out_gate_q    <= 1'b1;
            busy_q        <= 1'b0;
            burst_done_q  <= 1'b0;
            cycle_count_q <= '0;
            tgt_q         <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            msb_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            nco_clear_q   <= nco_clear_d;
            out_gate_q    <= out_gate_d;
            busy_q        <= busy_d;
            burst_done_q  <= burst_done_d;
            cycle_count_q <= cycle_count_d;
            tgt_q         <= tgt_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            // A held accumulator must not produce a false wrap on release
            msb_q         <= nco_clear_q ? 1'b0 : bus.phase_msb;
        end
    end

    assign bus.state       = state_q;
    assign bus.nco_clear   = nco_clear_q;
    assign bus.out_gate    = out_gate_q;
    assign bus.busy        = busy_q;
    assign bus.burst_done  = burst_done_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_burst_mode_controller.sv
// Directed bench for burst_mode_controller with a period-8 NCO model on phase_msb.
// Gate-high spans are one period-count plus one clk of wrap-detect latency.
module tb_burst_mode_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   hi;
    int   lo;
    logic [2:0] ph = 3'd0;

    burst_mode_controller_if #(.CYC_W(16), .GAP_W(24)) bus ();

    burst_mode_controller #(.CYC_W(16), .GAP_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered 3-bit accumulator stepping by 1: MSB period is 8 clks
    always @(posedge clk) ph <= bus.nco_clear ? 3'd0 : ph + 3'd1;
    assign bus.phase_msb = ph[2];

    always @(negedge clk) if (bus.burst_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && bus.state != s; i++) tick();
        check(tag, 32'(bus.state), 32'(s));
    endtask

    task automatic measure_high(output int n);
        n = 0;
        while (bus.out_gate && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (!bus.out_gate && n < 300) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.enable       = 1'b1;
        bus.trig_mode    = 1'b0;
        bus.trig         = 1'b0;
        bus.burst_cycles = 16'd3;
        bus.gap_ticks    = 24'd10;

        // Reset held with enable=1
        repeat (3) tick();
        check("rst_state", 32'(bus.state), 0);
        check("rst_nco_clear", 32'(bus.nco_clear), 0);
        check("rst_out_gate", 32'(bus.out_gate), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cycle_count", 32'(bus.cycle_count), 0);
        rst_n = 1'b1;
        tick();
        check("rel_nco_clear", 32'(bus.nco_clear), 1);
        check("rel_out_gate", 32'(bus.out_gate), 0);
        check("rel_state", 32'(bus.state), 1);

        // Auto-repeat, 3 periods, gap 10
        wait_state(2'd2, 5, "b1_enter");
        measure_high(hi);
        check("b1_high", 32'(hi), 25);
        check("b1_done", 32'(bus.burst_done), 1);
        check("b1_count", 32'(bus.cycle_count), 3);
        check("b1_state", 32'(bus.state), 3);
        measure_low(lo);
        check("b1_low", 32'(lo), 11);
        check("b1_done_cnt", 32'(done_cnt), 1);

        // Config change mid-burst only takes effect on the following burst
        bus.burst_cycles = 16'd5;
        measure_high(hi);
        check("b2_high", 32'(hi), 25);
        check("b2_count", 32'(bus.cycle_count), 3);
        measure_low(lo);
        check("b2_low", 32'(lo), 11);
        check("b2_done_cnt", 32'(done_cnt), 2);
        measure_high(hi);
        check("b3_high", 32'(hi), 41);
        check("b3_count", 32'(bus.cycle_count), 5);
        measure_low(lo);

        // Disable in BURST after first wrap
        for (int i = 0; i < 50 && bus.cycle_count != 16'd1; i++) tick();
        check("b4_count1", 32'(bus.cycle_count), 1);
        check("b3_done_cnt", 32'(done_cnt), 3);
        bus.enable = 1'b0;
        tick();
        check("dis_state", 32'(bus.state), 0);
        check("dis_out_gate", 32'(bus.out_gate), 1);
        check("dis_nco_clear", 32'(bus.nco_clear), 0);
        check("dis_busy", 32'(bus.busy), 0);
        check("dis_done", 32'(bus.burst_done), 0);
        check("dis_count", 32'(bus.cycle_count), 1);
        repeat (5) tick();
        check("dis_hold_state", 32'(bus.state), 0);
        check("dis_done_cnt", 32'(done_cnt), 3);

        // Reset pulse in GAP
        bus.burst_cycles = 16'd1;
        bus.gap_ticks    = 24'd20;
        bus.enable       = 1'b1;
        wait_state(2'd3, 100, "g6_enter");
        repeat (3) tick();
        check("g6_done_cnt", 32'(done_cnt), 4);
        rst_n            = 1'b0;
        bus.trig_mode    = 1'b1;
        bus.burst_cycles = 16'd0;
        bus.gap_ticks    = 24'd4;
        tick();
        check("g6_state", 32'(bus.state), 0);
        check("g6_nco_clear", 32'(bus.nco_clear), 0);
        check("g6_out_gate", 32'(bus.out_gate), 1);
        check("g6_busy", 32'(bus.busy), 0);
        check("g6_done", 32'(bus.burst_done), 0);
        check("g6_count", 32'(bus.cycle_count), 0);
        rst_n = 1'b1;
        tick();
        check("t_idle_state", 32'(bus.state), 0);
        check("t_idle_nco_clear", 32'(bus.nco_clear), 1);
        check("t_idle_out_gate", 32'(bus.out_gate), 0);

        // Triggered single-shot, burst_cycles=0 acts as 1
        repeat (20) tick();
        check("t_wait_state", 32'(bus.state), 0);
        check("t_wait_done_cnt", 32'(done_cnt), 4);
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        check("t_start", 32'(bus.state), 1);
        tick();
        check("t_burst", 32'(bus.state), 2);
        hi = 0;
        while (bus.out_gate && hi < 100) begin
            bus.trig = (hi == 2);
            hi++;
            tick();
        end
        bus.trig = 1'b0;
        check("t_high", 32'(hi), 9);
        check("t_gap_state", 32'(bus.state), 3);
        check("t_count", 32'(bus.cycle_count), 1);
        check("t_done", 32'(bus.burst_done), 1);
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        repeat (2) tick();
        check("t_gap_last", 32'(bus.state), 3);
        tick();
        check("t_back_idle", 32'(bus.state), 0);
        repeat (20) tick();
        check("t_stay_idle", 32'(bus.state), 0);
        check("t_done_cnt", 32'(done_cnt), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
